// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass and per-register pending-write scoreboard.
// Latency: reads and busy flags are combinational; writes and scoreboard updates take effect at the next rising edge.
// Backpressure: issue_ready drops when the addressed pending counter is at 3; a refused issue is ignored and must be retried.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    output logic                err_underflow
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [1:0]      cnt_q [NREG];
    logic [1:0]      cnt_d [NREG];
    logic            err_q;
    logic            err_d;

    logic            wr0_ok;
    logic            wr1_ok;
    logic [NREG-1:0] hit0;
    logic [NREG-1:0] hit1;
    logic            issue_zero;

    // Decode write ports: storage acceptance (drops writes to hardwired x0) and one-hot target per port.
    always_comb begin
        wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
        wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
        hit0   = '0;
        hit1   = '0;
        if (wr0_en) hit0[wr0_addr] = 1'b1;
        if (wr1_en) hit1[wr1_addr] = 1'b1;
    end

    // x0 never tracks pending writes, so issues to it are always accepted.
    assign issue_zero    = (ZERO_REG != 0) && (issue_rd == '0);
    assign issue_ready   = issue_zero || (cnt_q[issue_rd] != 2'd3);
    assign err_underflow = err_q;

    // Next storage contents: port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (wr0_ok) mem_d[wr0_addr] = wr0_data;
        if (wr1_ok) mem_d[wr1_addr] = wr1_data;
    end

    // Next pending counters: add the accepted issue, subtract write-backs, clamp at 0 and flag underflow.
    always_comb begin : sb_next
        logic [2:0] sum_v;
        logic [2:0] dec_v;
        logic [2:0] diff_v;
        logic       inc_v;
        sum_v  = '0;
        dec_v  = '0;
        diff_v = '0;
        inc_v  = 1'b0;
        err_d  = err_q;
        for (int r = 0; r < NREG; r++) begin
            inc_v  = issue_en && issue_ready && (issue_rd == AW'(r));
            sum_v  = {1'b0, cnt_q[r]} + {2'b00, inc_v};
            dec_v  = {2'b00, hit0[r]} + {2'b00, hit1[r]};
            diff_v = sum_v - dec_v;
            if ((ZERO_REG != 0) && (r == 0)) begin
                cnt_d[r] = 2'd0;
            end else if (dec_v > sum_v) begin
                cnt_d[r] = 2'd0;
                err_d    = 1'b1;
            end else if (diff_v > 3'd3) begin
                cnt_d[r] = 2'd3;
            end else begin
                cnt_d[r] = diff_v[1:0];
            end
        end
    end

    // State registers with synchronous reset of data, counters and the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Read ports: x0 first, then bypass from port 1, then port 0, then storage; busy nets out same-cycle write-backs.
    always_comb begin : rd_ports
        logic [AW-1:0] a_v;
        logic [1:0]    dec_v;
        a_v     = '0;
        dec_v   = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            a_v   = rd_addr[i*AW +: AW];
            dec_v = {1'b0, hit0[a_v]} + {1'b0, hit1[a_v]};
            if ((ZERO_REG != 0) && (a_v == '0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end else begin
                if ((BYPASS != 0) && wr1_en && (wr1_addr == a_v)) begin
                    rd_data[i*XLEN +: XLEN] = wr1_data;
                end else if ((BYPASS != 0) && wr0_en && (wr0_addr == a_v)) begin
                    rd_data[i*XLEN +: XLEN] = wr0_data;
                end else begin
                    rd_data[i*XLEN +: XLEN] = mem_q[a_v];
                end
                if (BYPASS != 0) begin
                    rd_busy[i] = cnt_q[a_v] > dec_v;
                end else begin
                    rd_busy[i] = cnt_q[a_v] != 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: three register-file configurations share one stimulus stream.
// A reference model predicts each cycle's outputs and queues them; a negedge monitor compares.
// Configs: 0 = default with bypass, 1 = default without bypass, 2 = NREG 16 / NRD 3 / XLEN 64.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        w0_en, w1_en, iss_en;
    logic [4:0]  w0_a, w1_a, iss_rd;
    logic [63:0] w0_d, w1_d;
    logic [4:0]  ra [4];

    logic [63:0]  a_rd_data, b_rd_data;
    logic [1:0]   a_busy, b_busy;
    logic         a_rdy, b_rdy, a_err, b_err;
    logic [191:0] c_rd_data;
    logic [2:0]   c_busy;
    logic         c_rdy, c_err;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .wr0_en(w0_en), .wr0_addr(w0_a), .wr0_data(w0_d[31:0]),
        .wr1_en(w1_en), .wr1_addr(w1_a), .wr1_data(w1_d[31:0]),
        .rd_addr({ra[1], ra[0]}), .rd_data(a_rd_data), .rd_busy(a_busy),
        .issue_en(iss_en), .issue_rd(iss_rd), .issue_ready(a_rdy), .err_underflow(a_err)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .wr0_en(w0_en), .wr0_addr(w0_a), .wr0_data(w0_d[31:0]),
        .wr1_en(w1_en), .wr1_addr(w1_a), .wr1_data(w1_d[31:0]),
        .rd_addr({ra[1], ra[0]}), .rd_data(b_rd_data), .rd_busy(b_busy),
        .issue_en(iss_en), .issue_rd(iss_rd), .issue_ready(b_rdy), .err_underflow(b_err)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst),
        .wr0_en(w0_en), .wr0_addr(w0_a[3:0]), .wr0_data(w0_d),
        .wr1_en(w1_en), .wr1_addr(w1_a[3:0]), .wr1_data(w1_d),
        .rd_addr({ra[2][3:0], ra[1][3:0], ra[0][3:0]}), .rd_data(c_rd_data), .rd_busy(c_busy),
        .issue_en(iss_en), .issue_rd(iss_rd[3:0]), .issue_ready(c_rdy), .err_underflow(c_err)
    );

    // ---------------- reference model ----------------
    int nreg_of [3] = '{32, 32, 16};
    int nrd_of  [3] = '{2, 2, 3};
    int xlen_of [3] = '{32, 32, 64};
    int byp_of  [3] = '{1, 0, 1};

    logic [63:0] m_mem [3][32];
    int          m_cnt [3][32];
    logic        m_err [3];

    typedef struct {
        int           cfg;
        int           cyc;
        logic [255:0] data;
        logic [3:0]   busy;
        logic         rdy;
        logic         err;
    } exp_t;

    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic logic [63:0] mask_of(int k);
        return (xlen_of[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Count of write ports targeting register a this cycle in config k.
    function automatic int wb_hits(int k, int a);
        int n;
        n = nreg_of[k];
        return ((w0_en && (int'(w0_a) % n == a)) ? 1 : 0) + ((w1_en && (int'(w1_a) % n == a)) ? 1 : 0);
    endfunction

    function automatic exp_t predict(int k);
        exp_t        e;
        int          n, a, eff;
        logic [63:0] v;
        n      = nreg_of[k];
        e.cfg  = k;
        e.cyc  = cyc;
        e.data = '0;
        e.busy = '0;
        for (int i = 0; i < nrd_of[k]; i++) begin
            a = int'(ra[i]) % n;
            if (a == 0) v = '0;
            else if (byp_of[k] != 0 && w1_en && int'(w1_a) % n == a) v = w1_d & mask_of(k);
            else if (byp_of[k] != 0 && w0_en && int'(w0_a) % n == a) v = w0_d & mask_of(k);
            else v = m_mem[k][a];
            if (xlen_of[k] == 64) e.data[i*64 +: 64] = v;
            else e.data[i*32 +: 32] = v[31:0];
            eff = m_cnt[k][a] - ((byp_of[k] != 0) ? wb_hits(k, a) : 0);
            e.busy[i] = (a != 0) && (eff > 0);
        end
        a     = int'(iss_rd) % n;
        e.rdy = (a == 0) || (m_cnt[k][a] != 3);
        e.err = m_err[k];
        return e;
    endfunction

    task automatic update(int k);
        int n, ir, c;
        bit accept;
        n  = nreg_of[k];
        ir = int'(iss_rd) % n;
        accept = iss_en && ((ir == 0) || (m_cnt[k][ir] != 3));
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r] = '0;
                m_cnt[k][r] = 0;
            end
            m_err[k] = 1'b0;
        end else begin
            for (int r = 1; r < n; r++) begin
                c = m_cnt[k][r] + ((accept && ir == r) ? 1 : 0) - wb_hits(k, r);
                if (c < 0) begin
                    c = 0;
                    m_err[k] = 1'b1;
                end
                if (c > 3) c = 3;
                m_cnt[k][r] = c;
            end
            if (w0_en && int'(w0_a) % n != 0) m_mem[k][int'(w0_a) % n] = w0_d & mask_of(k);
            if (w1_en && int'(w1_a) % n != 0) m_mem[k][int'(w1_a) % n] = w1_d & mask_of(k);
        end
    endtask

    // One clock of stimulus: queue predictions, let the edge happen, advance the model.
    task automatic step();
        for (int k = 0; k < 3; k++) sb_q.push_back(predict(k));
        @(posedge clk);
        for (int k = 0; k < 3; k++) update(k);
        cyc++;
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; w0_en = 1'b0; w1_en = 1'b0; iss_en = 1'b0;
    endtask

    task automatic wr0(input int a, input logic [63:0] d);
        w0_en = 1'b1; w0_a = 5'(a); w0_d = d;
    endtask

    task automatic wr1(input int a, input logic [63:0] d);
        w1_en = 1'b1; w1_a = 5'(a); w1_d = d;
    endtask

    task automatic iss(input int a);
        iss_en = 1'b1; iss_rd = 5'(a);
    endtask

    task automatic rd(input int a0, input int a1, input int a2);
        ra[0] = 5'(a0); ra[1] = 5'(a1); ra[2] = 5'(a2); ra[3] = '0;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input exp_t e, input logic [255:0] act, input logic [255:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cfg%0d cyc%0d: got %h expected %h", name, e.cfg, e.cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t         e;
        logic [255:0] od;
        logic [3:0]   ob;
        logic         orr, oe;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.cfg)
                0:       begin od = {192'b0, a_rd_data}; ob = {2'b0, a_busy}; orr = a_rdy; oe = a_err; end
                1:       begin od = {192'b0, b_rd_data}; ob = {2'b0, b_busy}; orr = b_rdy; oe = b_err; end
                default: begin od = {64'b0, c_rd_data};  ob = {1'b0, c_busy}; orr = c_rdy; oe = c_err; end
            endcase
            chk("rd_data", e, od, e.data);
            chk("rd_busy", e, 256'(ob), 256'(e.busy));
            chk("issue_ready", e, 256'(orr), 256'(e.rdy));
            chk("err_underflow", e, 256'(oe), 256'(e.err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r] = '0;
                m_cnt[k][r] = 0;
            end
            m_err[k] = 1'b0;
        end
        idle();
        rst = 1'b1;
        w0_a = '0; w1_a = '0; w0_d = '0; w1_d = '0; iss_rd = '0;
        rd(0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values, then write/read and x0 behaviour.
        step();
        wr0(5, 64'hDEAD_BEEF_DEAD_BEEF); rd(5, 0, 5); step();
        idle(); rd(5, 0, 0); step();
        wr0(0, 64'h1234); rd(0, 5, 0); step();
        idle(); step();

        // Same-address dual write and bypass.
        wr0(7, 64'hA); wr1(7, 64'hB); rd(7, 7, 7); step();
        idle(); step();

        // Scoreboard basic on x3.
        iss(3); rd(3, 3, 3); step();
        idle(); step();
        wr0(3, 64'h33); step();
        idle(); step();

        // Saturation on x9.
        rd(9, 9, 9);
        for (int i = 0; i < 3; i++) begin iss(9); step(); end
        for (int i = 0; i < 2; i++) begin iss(9); step(); end
        idle(); step();
        wr1(9, 64'h99); step();
        idle(); iss(9); wr0(9, 64'h98); step();
        idle(); step();

        // Underflow after a mid-operation reset, stickiness, and clearing by reset.
        rd(4, 6, 4);
        iss(4); step();
        iss(6); step();
        idle(); rst = 1'b1; step();
        idle(); wr0(4, 64'h44); step();
        idle(); step();
        iss(6); step();
        idle(); rst = 1'b1; step();
        idle(); step();

        // Double write-back to a single-pending register underflows.
        iss(2); rd(2, 2, 2); step();
        idle(); wr0(2, 64'h1); wr1(2, 64'h2); step();
        idle(); rst = 1'b1; step();

        // Randomised traffic biased towards a small set of registers.
        idle();
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 79) == 0);
            w0_en  = ($urandom_range(0, 2) == 0);
            w1_en  = ($urandom_range(0, 3) == 0);
            iss_en = ($urandom_range(0, 1) == 0);
            w0_a   = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            w1_a   = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            iss_rd = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            w0_d   = {$urandom, $urandom};
            w1_d   = {$urandom, $urandom};
            for (int i = 0; i < 4; i++)
                ra[i] = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            step();
        end

        idle();
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
